inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Program-counter and fetch sequencer that drives the InstAddress pointer of the 9-bit instruction ROM.
- Sequences execution from Start to Halt.
- Applies sequential, absolute-branch and PC-relative-branch updates.
- Supports pipeline stalls.
- Counts retired instructions for the testbench and performance reporting.
- Sits between the top-level testbench handshake (Start/Done) and the decoder/ALU branch outputs.

Parameters:
IW, 16, instruction address width; must match the ROM address width.
OW, 8, width of the signed relative branch offset.
CW, 16, width of the retired-instruction counter.
START_ADDR, 0, PC value loaded on reset and on each Start.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  begin execution from START_ADDR; sampled in IDLE and DONE only.
Stall  input  1  freeze the fetch this cycle; valid in RUN only.
HaltReq  input  1  current instruction is halt; valid in RUN only.
BranchAbs  input  1  take an absolute jump to Target.
Target  input  IW  absolute branch destination.
BranchRel  input  1  take a relative branch by Offset.
Offset  input  OW  two's-complement relative offset, added to the current PC.
InstAddress  output  IW  registered PC; connects to the ROM address input.
Running  output  1  high while the FSM is in RUN.
Done  output  1  high while the FSM is in DONE.
InstCount  output  CW  number of retired instructions since the last Start.

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-RUN):
  - state=IDLE, InstAddress=START_ADDR, InstCount=0, Running=0, Done=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE:
  - Start=1: next state RUN, InstAddress=START_ADDR, InstCount=0.
  - Otherwise hold.
  - Stall, HaltReq and branch inputs are ignored.
- RUN: per-cycle priority is Stall > HaltReq > BranchAbs > BranchRel > sequential.
  - Stall=1: PC, count and state all unchanged; every other input is ignored.
  - HaltReq=1: next state DONE, PC held, InstCount+1.
  - BranchAbs=1: PC<=Target, InstCount+1. If BranchRel is also high, BranchAbs wins.
  - BranchRel=1: PC<=PC+sign_extend(Offset). The sum is IW bits, modulo 2^IW (wraps both directions, no error).
  - Sequential (none of the above): PC<=PC+1. All-ones wraps to 0.
  - Start is ignored in RUN.
  - Fetch latency: the new InstAddress is visible the cycle after the edge on which the decision is sampled, so the ROM output follows combinationally in that same cycle.
- DONE:
  - Done=1, PC and InstCount held.
  - Start=1: next state RUN, PC=START_ADDR, InstCount=0; Done drops on that edge.
- InstCount saturates at 2^CW-1 and does not wrap.
- Running and Done are never both high. Both are low only in IDLE.
- Offset of 0 is a legal self-loop: PC is unchanged and the count still increments.

Test Plan:
1. Reset, then Start pulse for 1 cycle, then 5 plain RUN cycles -> InstAddress sequence 0,0,1,2,3,4,5; Running=1 from the cycle after Start; InstCount=5.
2. In RUN at PC=0x0010: BranchRel with Offset=8'hFC (-4) -> next PC=0x000C. Then BranchAbs with Target=0x1234 and BranchRel=1 at the same time -> next PC=0x1234 (absolute wins).
3. At PC=0xFFFF assert nothing -> PC=0x0000. At PC=0x0002 with Offset=8'hF0 -> PC=0xFFF2. Both wrap silently.
4. Hold Stall for 3 cycles with HaltReq=1 and BranchAbs=1 also high -> PC, InstCount and state unchanged for all 3 cycles. Release Stall with HaltReq=1 -> DONE next cycle, Done=1, InstCount incremented exactly once.
5. In DONE, assert Start -> PC=START_ADDR, InstCount=0, Running=1, Done=0 on the next cycle. Assert Reset mid-RUN at PC=0x0033 -> next cycle IDLE, PC=0, all outputs 0.
6. With CW=4, run 20 non-stalled cycles -> InstCount stops at 15. Start asserted during RUN -> no effect on PC or count.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Program counter and fetch sequencer for the instruction ROM: runs from Start to Halt,
// applies sequential, absolute and PC-relative updates, honours stalls and counts retired instructions.
module inst_fetch_ctrl #(
   parameter int IW = 16,
   parameter int OW = 8,
   parameter int CW = 16,
   parameter logic [IW-1:0] START_ADDR = '0
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Stall,
   input  logic          HaltReq,
   input  logic          BranchAbs,
   input  logic [IW-1:0] Target,
   input  logic          BranchRel,
   input  logic [OW-1:0] Offset,
   output logic [IW-1:0] InstAddress,
   output logic          Running,
   output logic          Done,
   output logic [CW-1:0] InstCount,
   output logic [1:0]    dbg_state
);

   // Handshake: Start is a level sampled only in IDLE/DONE; Done stays high until the
   // next accepted Start, which drops it on the same edge the run begins.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] off_ext;

   assign off_ext = IW'($signed(Offset));

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_ADDR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // A stalled cycle retires nothing; every other RUN cycle retires one instruction.
            if (!Stall) begin
               if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
               if (HaltReq)        state_d = S_DONE;
               else if (BranchAbs) pc_d    = Target;
               else if (BranchRel) pc_d    = pc_q + off_ext;
               else                pc_d    = pc_q + IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign InstAddress = pc_q;
   assign InstCount   = cnt_q;
   assign Running     = (state_q == S_RUN);
   assign Done        = (state_q == S_DONE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized and directed bench for inst_fetch_ctrl against a behavioural model of the
// fetch rules; a second instance with a 4-bit counter exercises count saturation.
module tb_inst_fetch_ctrl;

   localparam int IW = 16;
   localparam int OW = 8;

   logic          CLK = 1'b0;
   logic          Reset, Start, Stall, HaltReq, BranchAbs, BranchRel;
   logic [IW-1:0] Target;
   logic [OW-1:0] Offset;
   logic [IW-1:0] InstAddress, addr4;
   logic          Running, Done, run4, done4;
   logic [15:0]   InstCount;
   logic [3:0]    count4;
   logic [1:0]    dbg_state, dbg4;

   int checks   = 0;
   int failures = 0;

   // model: mode 0 idle, 1 run, 2 done; pc and count as plain integers
   int m_mode, m_pc, m_cnt;
   logic [IW-1:0] exp_q[$];

   always #5 CLK = ~CLK;

   inst_fetch_ctrl #(.IW(IW), .OW(OW), .CW(16)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall), .HaltReq(HaltReq),
      .BranchAbs(BranchAbs), .Target(Target), .BranchRel(BranchRel), .Offset(Offset),
      .InstAddress(InstAddress), .Running(Running), .Done(Done), .InstCount(InstCount),
      .dbg_state(dbg_state));

   inst_fetch_ctrl #(.IW(IW), .OW(OW), .CW(4)) dut4 (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall), .HaltReq(HaltReq),
      .BranchAbs(BranchAbs), .Target(Target), .BranchRel(BranchRel), .Offset(Offset),
      .InstAddress(addr4), .Running(run4), .Done(done4), .InstCount(count4),
      .dbg_state(dbg4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic st, input logic stl, input logic hlt,
                        input logic ab, input logic [IW-1:0] tgt, input logic rl,
                        input logic [OW-1:0] off);
      Reset = rst; Start = st; Stall = stl; HaltReq = hlt;
      BranchAbs = ab; Target = tgt; BranchRel = rl; Offset = off;
   endtask

   task automatic model_step();
      int o;
      if (Reset) begin
         m_mode = 0; m_pc = 0; m_cnt = 0;
      end else if (m_mode != 1) begin
         if (Start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
      end else if (!Stall) begin
         m_cnt = m_cnt + 1;
         o = int'(Offset);
         if (o >= 128) o = o - 256;
         if (HaltReq)        m_mode = 2;
         else if (BranchAbs) m_pc = int'(Target);
         else if (BranchRel) m_pc = ((m_pc + o) % 65536 + 65536) % 65536;
         else                m_pc = (m_pc + 1) % 65536;
      end
      exp_q.push_back(IW'(m_pc));
   endtask

   task automatic compare_all();
      logic [IW-1:0] e_pc;
      int e16, e4;
      e_pc = exp_q.pop_front();
      e16 = (m_cnt > 65535) ? 65535 : m_cnt;
      e4  = (m_cnt > 15) ? 15 : m_cnt;
      check("pc",      32'(InstAddress), 32'(e_pc));
      check("running", 32'(Running),     32'(m_mode == 1));
      check("done",    32'(Done),        32'(m_mode == 2));
      check("count",   32'(InstCount),   32'(e16));
      check("count4",  32'(count4),      32'(e4));
      check("pc4",     32'(addr4),       32'(e_pc));
   endtask

   // one clock: inputs already applied, model advances on the edge, outputs checked 1ns later
   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic plain(input int n);
      drive(0, 0, 0, 0, 0, '0, 0, '0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, '0, 0, '0);
      cycle();
   endtask

   task automatic do_start();
      drive(0, 1, 0, 0, 0, '0, 0, '0);
      cycle();
   endtask

   initial begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
      drive(1, 0, 0, 0, 0, '0, 0, '0);
      @(posedge CLK); #1;
      do_reset();

      // start, five sequential fetches
      do_start();
      plain(5);
      check("seq_pc_5", 32'(InstAddress), 32'h5);
      check("seq_cnt_5", 32'(InstCount), 32'd5);

      // relative back by 4, then absolute beats relative
      drive(0, 0, 0, 0, 1, 16'h0010, 0, '0); cycle();
      drive(0, 0, 0, 0, 0, '0, 1, 8'hFC);     cycle();
      check("rel_neg", 32'(InstAddress), 32'h000C);
      drive(0, 0, 0, 0, 1, 16'h1234, 1, 8'h40); cycle();
      check("abs_wins", 32'(InstAddress), 32'h1234);

      // wrap both directions; zero offset self-loop
      drive(0, 0, 0, 0, 1, 16'hFFFF, 0, '0); cycle();
      plain(1);
      check("wrap_up", 32'(InstAddress), 32'h0000);
      drive(0, 0, 0, 0, 1, 16'h0002, 0, '0); cycle();
      drive(0, 0, 0, 0, 0, '0, 1, 8'hF0);     cycle();
      check("wrap_down", 32'(InstAddress), 32'hFFF2);
      drive(0, 0, 0, 0, 0, '0, 1, 8'h00);     cycle();
      check("self_loop", 32'(InstAddress), 32'hFFF2);

      // start ignored in RUN
      drive(0, 1, 0, 0, 0, '0, 0, '0); cycle();
      check("start_in_run", 32'(InstAddress), 32'hFFF3);

      // stall dominates halt and branch, then halt
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 1, 1, 16'hABCD, 0, '0);
         cycle();
      end
      check("stall_pc", 32'(InstAddress), 32'hFFF3);
      drive(0, 0, 0, 1, 0, '0, 0, '0); cycle();
      check("halt_done", 32'(Done), 32'd1);
      plain(3);
      check("done_hold", 32'(InstAddress), 32'hFFF3);

      // restart from DONE, then reset mid-run
      do_start();
      check("restart_cnt", 32'(InstCount), 32'd0);
      drive(0, 0, 0, 0, 1, 16'h0033, 0, '0); cycle();
      do_reset();
      check("reset_mid_pc", 32'(InstAddress), 32'h0);
      check("reset_mid_run", 32'(Running), 32'd0);

      // saturation of the 4-bit counter
      do_start();
      plain(20);
      check("sat4", 32'(count4), 32'd15);
      check("nosat16", 32'(InstCount), 32'd20);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 9) == 0), IW'($urandom),
               ($urandom_range(0, 2) == 0), OW'($urandom));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
